alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked sequential ALU. Single-cycle ops (add/sub/logic/
//             shift/rotate/compare) complete in one cycle; multiply is an
//             iterative shift-add taking WIDTH cycles. Results and flags are
//             registered and held until the consumer accepts them.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready  - request handshake (ready only in IDLE)
//             a, b [WIDTH]       - unsigned operands
//             alu_sel [4]        - operation select
//             out_valid/out_ready- result handshake (valid only in DONE)
//             alu_out [WIDTH]    - registered result
//             carry_out, zero, overflow, illegal - registered flags
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int         CNT_W       = $clog2(WIDTH);
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_MUL    = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;
    localparam logic [3:0] c_OP_MUL    = 4'b1000;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_init;      // low until the first edge after reset release
    logic [2*WIDTH-1:0] r_acc;       // {partial product high, multiplier/low product}
    logic [WIDTH-1:0]   r_mcand;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_last;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_cy;
    logic               w_ov;
    logic               w_ill;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_is_mul   = (alu_sel == c_OP_MUL);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_last = (r_state == c_ST_MUL) && (r_cnt == CNT_W'(WIDTH - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept)   w_state_nxt = w_is_mul ? c_ST_MUL : c_ST_DONE;
            c_ST_MUL:  if (w_mul_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE: if (out_ready)  w_state_nxt = c_ST_IDLE;
            default:                   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_ST_IDLE) && r_init;
        out_valid = (r_state == c_ST_DONE);
    end

    // ------------------------------------------------- single-cycle datapath
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};   // MSB is the borrow

    always_comb begin
        w_res = '0;
        w_cy  = 1'b0;
        w_ov  = 1'b0;
        w_ill = 1'b0;
        case (alu_sel)
            4'b0000: begin
                {w_cy, w_res} = w_add;
                w_ov = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: begin
                {w_cy, w_res} = w_sub;
                w_ov = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: w_res = a & b;
            4'b0011: w_res = a | b;
            4'b0100: w_res = a ^ b;
            4'b0101: w_res = ~a;
            4'b0110: begin
                w_res = {a[WIDTH-2:0], 1'b0};
                w_cy  = a[WIDTH-1];
            end
            4'b0111: begin
                w_res = {1'b0, a[WIDTH-1:1]};
                w_cy  = a[0];
            end
            4'b1000: w_res = '0;    // produced by the iterative path
            4'b1001: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1010: w_res = {a[WIDTH-2:0], a[WIDTH-1]};
            4'b1011: w_res = {a[0], a[WIDTH-1:1]};
            default: w_ill = 1'b1;
        endcase
    end

    // ---------------------------------------------------- shift-add multiply
    // Each step adds the multiplicand into the upper half when the current
    // multiplier LSB is set, then shifts the whole accumulator right by one;
    // after WIDTH steps the accumulator holds the full 2*WIDTH product.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_mcand <= a;
            r_cnt   <= '0;
        end else if (r_state == c_ST_MUL) begin
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------ result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            alu_out   <= w_res;
            carry_out <= w_cy;
            zero      <= (w_res == '0);
            overflow  <= w_ov;
            illegal   <= w_ill;
        end else if (w_mul_last) begin
            alu_out   <= w_acc_nxt[WIDTH-1:0];
            carry_out <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=8) using an arithmetic
//             reference model, directed cases and random operations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] alu_out;
    logic         carry_out;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int n_assert = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {illegal, overflow, carry, result[7:0]}.
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic [3:0] s);
        int ua, ub, sa, sb, r, c, v, il, p;
        ua = int'(x); ub = int'(y);
        sa = int'($signed(x)); sb = int'($signed(y));
        r = 0; c = 0; v = 0; il = 0;
        case (s)
            4'd0:  begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); r = r % 256; end
            4'd1:  begin r = (ua - ub + 256) % 256; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = 255 - ua;
            4'd6:  begin r = (ua * 2) % 256; c = (ua >= 128); end
            4'd7:  begin r = ua / 2; c = ua % 2; end
            4'd8:  begin p = ua * ub; r = p % 256; c = (p > 255); end
            4'd9:  r = (ua < ub) ? 1 : 0;
            4'd10: r = (ua * 2) % 256 + ua / 128;
            4'd11: r = ua / 2 + (ua % 2) * 128;
            default: il = 1;
        endcase
        return {il[0], v[0], c[0], r[7:0]};
    endfunction

    // Issue one operation, check latency, result, hold behaviour and release.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] ts,
                          input int hold);
        logic [10:0] m;
        int          lat;
        int          exp_lat;
        logic        rdy_seen;
        logic        stable_bad;
        m        = model(ta, tb_, ts);
        exp_lat  = (ts == 4'b1000) ? W + 1 : 1;
        rdy_seen = 1'b0;
        stable_bad = 1'b0;
        chk("in_ready_idle", in_ready, 1);
        a = ta; b = tb_; alu_sel = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        lat = 1;
        a = W'($urandom); b = W'($urandom); alu_sel = 4'($urandom);
        in_valid = 1'($urandom);
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            @(negedge clk);
            lat++;
            a = W'($urandom); b = W'($urandom); alu_sel = 4'($urandom);
        end
        rdy_seen |= in_ready;
        chk("latency", lat, exp_lat);
        chk("alu_out", alu_out, m[7:0]);
        chk("carry_out", carry_out, m[8]);
        chk("overflow", overflow, m[9]);
        chk("illegal", illegal, m[10]);
        chk("zero", zero, (m[7:0] == 8'h00));
        repeat (hold) begin
            @(negedge clk);
            rdy_seen |= in_ready;
            if (!out_valid || alu_out !== m[7:0] || carry_out !== m[8] ||
                overflow !== m[9] || illegal !== m[10])
                stable_bad = 1'b1;
            a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
        end
        if (hold > 0) chk("held_stable", stable_bad, 0);
        chk("in_ready_busy", rdy_seen, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_consumed", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        logic seen;
        // ---- reset state
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_flags", {carry_out, zero, overflow, illegal}, 4'b0000);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_post_release", in_ready, 1);

        // ---- directed cases
        run_op(8'hF0, 8'h20, 4'b0000, 0);   // add with carry
        run_op(8'h80, 8'h01, 4'b0001, 0);   // sub signed overflow
        run_op(8'h05, 8'h05, 4'b0001, 0);   // sub to zero
        run_op(8'h10, 8'h11, 4'b1000, 0);   // multiply, upper bits nonzero
        run_op(8'h81, 8'h00, 4'b0110, 5);   // shl under backpressure
        run_op(8'h00, 8'h00, 4'b1110, 0);   // illegal
        run_op(8'h01, 8'h00, 4'b1011, 0);   // rotate right
        run_op(8'h7F, 8'h01, 4'b0000, 1);   // add signed overflow
        run_op(8'hFF, 8'hFF, 4'b1000, 2);   // multiply max
        run_op(8'h03, 8'h09, 4'b1001, 0);   // less-than true

        // ---- reset in the 4th cycle of a multiply
        a = 8'h10; b = 8'h11; alu_sel = 4'b1000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_alu_out", alu_out, 0);
        chk("abort_flags", {out_valid, carry_out, zero, overflow, illegal}, 5'b00000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready_release", in_ready, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= out_valid;
        end
        chk("abort_no_result", seen, 0);
        run_op(8'h01, 8'h01, 4'b0000, 0);

        // ---- random operations
        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
